// File: rtl/counter_pkg.sv
// Shared definitions for the counter blocks: FSM state encoding, run mode
// encoding and default width constants.
package counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_ONE_SHOT = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_t;

  localparam int unsigned DEF_COUNT_WIDTH    = 32'd10;
  localparam int unsigned DEF_PRESCALE_WIDTH = 32'd4;

endpackage

// File: rtl/tick_prescaler.sv
// Tick divider for down_counter: one tick every (div+1) enabled cycles.
// Only built when DOWN_COUNTER_PRESCALE_EN is defined.
`ifdef DOWN_COUNTER_PRESCALE_EN
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_r;
  logic             wrap_s;

  // >= keeps the divider from overrunning if div shrinks mid-count
  assign wrap_s = (cnt_r >= div);
  assign tick   = enable && wrap_s;

  // Enabled-cycle counter; clear has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (enable) begin
      if (wrap_s) begin
        cnt_r <= {WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule
`endif

// File: rtl/down_counter.sv
// Loadable down counter with one-shot / periodic modes and a terminal-count pulse.
// Optional tick prescaler compiled in with DOWN_COUNTER_PRESCALE_EN.
module down_counter
  import counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH,
  parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                      i_CLK,
  input  logic                      i_RST_N,
  input  logic                      i_EN,
  input  logic                      i_START,
  input  logic                      i_STOP,
  input  logic                      i_AUTO_RELOAD,
  input  logic [COUNT_WIDTH-1:0]    i_LOAD_VAL,
`ifdef DOWN_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] i_PRESCALE,
`endif
  output logic [COUNT_WIDTH-1:0]    o_CNT,
  output logic                      o_BUSY,
  output logic                      o_DONE
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r, state_nxt_s;
  mode_t                    mode_r, mode_nxt_s;
  logic [COUNT_WIDTH-1:0]   cnt_r, cnt_nxt_s;
  logic [COUNT_WIDTH-1:0]   reload_r, reload_nxt_s;
  logic                     done_r, done_nxt_s;
  logic                     run_en_s;
  logic                     tick_s;
  logic                     pre_clear_s;

  assign run_en_s = i_EN && (state_r == ST_RUN);

`ifdef DOWN_COUNTER_PRESCALE_EN
  tick_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk    (i_CLK),
    .rst_n  (i_RST_N),
    .clear  (pre_clear_s),
    .enable (run_en_s),
    .div    (i_PRESCALE),
    .tick   (tick_s)
  );
`else
  logic [PRESCALE_WIDTH-1:0] unused_prescale_s;
  assign unused_prescale_s = {PRESCALE_WIDTH{pre_clear_s}};
  assign tick_s            = run_en_s;
`endif

  // Next-state and datapath decode; priority is stop, then start, then tick
  always_comb begin
    state_nxt_s  = state_r;
    mode_nxt_s   = mode_r;
    cnt_nxt_s    = cnt_r;
    reload_nxt_s = reload_r;
    done_nxt_s   = 1'b0;
    pre_clear_s  = 1'b0;
    if (i_STOP) begin
      state_nxt_s = ST_IDLE;
      pre_clear_s = 1'b1;
    end else if (i_START) begin
      cnt_nxt_s    = i_LOAD_VAL;
      reload_nxt_s = i_LOAD_VAL;
      mode_nxt_s   = i_AUTO_RELOAD ? MODE_PERIODIC : MODE_ONE_SHOT;
      pre_clear_s  = 1'b1;
      // A zero load terminates at once and never enters RUN
      if (i_LOAD_VAL == CNT_ZERO) begin
        state_nxt_s = ST_IDLE;
        done_nxt_s  = 1'b1;
      end else begin
        state_nxt_s = ST_RUN;
      end
    end else if (tick_s) begin
      case (state_r)
        ST_RUN: begin
          if (cnt_r > CNT_ONE) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end else if (cnt_r == CNT_ONE) begin
            done_nxt_s = 1'b1;
            if (mode_r == MODE_PERIODIC) begin
              cnt_nxt_s = reload_r;
            end else begin
              cnt_nxt_s   = CNT_ZERO;
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_r  <= ST_IDLE;
      mode_r   <= MODE_ONE_SHOT;
      cnt_r    <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      mode_r   <= mode_nxt_s;
      cnt_r    <= cnt_nxt_s;
      reload_r <= reload_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign o_CNT  = cnt_r;
  assign o_BUSY = (state_r == ST_RUN);
  assign o_DONE = done_r;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_down_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [9:0] load_val;
  logic [3:0] prescale;
  logic [9:0] cnt;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // behavioural model state
  int exp_cnt;
  bit exp_run;
  bit exp_done;
  int m_reload;
  bit m_periodic;
  int m_en_cycles;

  down_counter dut (
    .i_CLK         (clk),
    .i_RST_N       (rst_n),
    .i_EN          (en),
    .i_START       (start),
    .i_STOP        (stop),
    .i_AUTO_RELOAD (auto_reload),
    .i_LOAD_VAL    (load_val),
`ifdef DOWN_COUNTER_PRESCALE_EN
    .i_PRESCALE    (prescale),
`endif
    .o_CNT         (cnt),
    .o_BUSY        (busy),
    .o_DONE        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_cnt     = 0;
    exp_run     = 1'b0;
    exp_done    = 1'b0;
    m_reload    = 0;
    m_periodic  = 1'b0;
    m_en_cycles = 0;
  endtask

  // What the next clock edge must produce, from the current inputs
  task automatic model_step();
    exp_done = 1'b0;
    if (stop) begin
      exp_run     = 1'b0;
      m_en_cycles = 0;
    end else if (start) begin
      exp_cnt     = int'(load_val);
      m_reload    = int'(load_val);
      m_periodic  = auto_reload;
      m_en_cycles = 0;
      exp_run     = (load_val != 10'd0);
      exp_done    = (load_val == 10'd0);
    end else if (exp_run && en) begin
      m_en_cycles++;
      if (m_en_cycles == int'(prescale) + 1) begin
        m_en_cycles = 0;
        if (exp_cnt > 1) begin
          exp_cnt--;
        end else begin
          exp_done = 1'b1;
          if (m_periodic) exp_cnt = m_reload;
          else begin
            exp_cnt = 0;
            exp_run = 1'b0;
          end
        end
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_cnt", int'(cnt), exp_cnt);
      chk("model_busy", int'(busy), int'(exp_run));
      chk("model_done", int'(done), int'(exp_done));
    end
  end

  task automatic step(input logic s_stop, input logic s_start, input logic s_ar,
                      input logic [9:0] s_load, input logic s_en, input logic [3:0] s_pre);
    stop        = s_stop;
    start       = s_start;
    auto_reload = s_ar;
    load_val    = s_load;
    en          = s_en;
    prescale    = s_pre;
    model_step();
    @(negedge clk);
    #1;
  endtask

  int exp_p[6] = '{2, 1, 3, 2, 1, 3};
  int exp_g[5] = '{9, 9, 8, 7, 7};
  bit en_g[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; load_val = 10'd0; prescale = 4'd0;
    model_reset();
    #1;
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // one-shot load 5
    step(1'b0, 1'b1, 1'b0, 10'd5, 1'b1, 4'd0);
    chk("oneshot_load_cnt", int'(cnt), 5);
    chk("oneshot_load_busy", int'(busy), 1);
    for (int k = 4; k >= 0; k--) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
      chk("oneshot_cnt", int'(cnt), k);
      chk("oneshot_done", int'(done), (k == 0) ? 1 : 0);
      chk("oneshot_busy", int'(busy), (k == 0) ? 0 : 1);
    end
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("oneshot_after_done", int'(done), 0);
    chk("oneshot_after_cnt", int'(cnt), 0);

    // periodic load 3
    step(1'b0, 1'b1, 1'b1, 10'd3, 1'b1, 4'd0);
    chk("periodic_load_cnt", int'(cnt), 3);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
      chk("periodic_cnt", int'(cnt), exp_p[i]);
      chk("periodic_done", int'(done), (exp_p[i] == 3) ? 1 : 0);
      chk("periodic_busy", int'(busy), 1);
    end
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("periodic_stop_busy", int'(busy), 0);

    // stop at count 2
    step(1'b0, 1'b1, 1'b0, 10'd5, 1'b1, 4'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("pre_stop_cnt", int'(cnt), 2);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("stop_cnt", int'(cnt), 2);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("stop_hold_cnt", int'(cnt), 2);

    // start on the terminal tick
    step(1'b0, 1'b1, 1'b0, 10'd2, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("collide_pre_cnt", int'(cnt), 1);
    step(1'b0, 1'b1, 1'b0, 10'd7, 1'b1, 4'd0);
    chk("collide_cnt", int'(cnt), 7);
    chk("collide_done", int'(done), 0);
    chk("collide_busy", int'(busy), 1);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 4'd0);

    // zero load
    step(1'b0, 1'b1, 1'b1, 10'd0, 1'b1, 4'd0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("zero_done_clear", int'(done), 0);
    chk("zero_busy_after", int'(busy), 0);

    // enable gating
    step(1'b0, 1'b1, 1'b0, 10'd10, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, en_g[i], 4'd0);
      chk("gate_cnt", int'(cnt), exp_g[i]);
    end

    // asynchronous reset mid-run
    step(1'b0, 1'b1, 1'b0, 10'd6, 1'b1, 4'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
    chk("prereset_cnt", int'(cnt), 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd0);
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

`ifdef DOWN_COUNTER_PRESCALE_EN
    // prescale 2, load 2: terminal after 6 enabled cycles
    step(1'b0, 1'b1, 1'b0, 10'd2, 1'b1, 4'd2);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd2);
      chk("prescale_done", int'(done), (i == 5) ? 1 : 0);
    end
`endif

    // randomized traffic
    begin
      logic [3:0] cur_pre;
      cur_pre = 4'd0;
      for (int n = 0; n < 3000; n++) begin
        logic       r_stop, r_start, r_ar, r_en;
        logic [9:0] r_load;
        r_stop  = ($urandom_range(0, 31) == 0);
        r_start = ($urandom_range(0, 15) == 0);
        r_ar    = 1'($urandom_range(0, 1));
        r_en    = ($urandom_range(0, 3) != 0);
        r_load  = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(0, 1023))
                                               : 10'($urandom_range(0, 12));
`ifdef DOWN_COUNTER_PRESCALE_EN
        if (r_start) cur_pre = 4'($urandom_range(0, 3));
`endif
        step(r_stop, r_start, r_ar, r_load, r_en, cur_pre);
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
